pkt_rr_mux_arb: RTL and testbench
=================================

# pkt_rr_mux_arb

Round-robin packet arbiter that shares one `mux` datapath among `NR` requesters, each driving a valid/ready stream with a last-beat marker. It selects one requester and locks the grant until that requester's packet completes. The winner drives the `mux` select, and the selected beat goes into a registered output stage with backpressure. The block sits between parallel producers (e.g. per-subspace codebook/distance lanes) and a single shared consumer.

## Interface
Parameters:
- `DW`, 4: data width per beat.
- `NR`, 4: number of requesters; must be ≥ 2, need not be a power of two.
- `SW` (localparam): `` `log2(NR) ``, the select width.

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — reset; synchronous, active-high.
- `req_val`  in  NR  — per-requester beat valid.
- `req_lst`  in  NR  — per-requester last beat of packet; meaningful only with `req_val`.
- `req_dat`  in  DW*NR  — packed requester data; requester i is at `[DW*i +: DW]`.
- `req_rdy`  out  NR  — per-requester accept; combinational; at most one bit high.
- `out_val`  out  1  — output beat valid; registered.
- `out_lst`  out  1  — output last beat; registered.
- `out_dat`  out  DW  — output data; registered.
- `out_src`  out  SW  — index of the requester that produced the beat; registered.
- `out_rdy`  in  1  — consumer accept.

## Operation
- Internal state:
  - `ptr` [SW]: round-robin priority start.
  - `st` ∈ {IDLE, LOCK}.
  - `gnt` [SW]: locked requester.
- `ld = !out_val || out_rdy`: the output register may load this cycle.
- Winner (IDLE only): the first i with `req_val[i]=1`, searching `ptr`, `ptr+1`, … modulo `NR`. The increment wraps from `NR-1` to 0, also for non-power-of-two `NR`.
- `sel = (st==LOCK) ? gnt : winner`. `sel` drives the `sel` input of an instance of `mux` (`DW`, `MW=NR`); `inp=req_dat`.
- `req_rdy[i] = ld && req_val[sel] && (i==sel) && !rst`.
  - Ready may depend on valid.
  - Requesters must not wait for `req_rdy` before asserting `req_val`.
- Accept: `acc = ld && req_val[sel]` (and, in IDLE, some request exists).
- IDLE:
  - `acc` with `req_lst[sel]=1`: stay IDLE; `ptr <= sel+1 mod NR`.
  - `acc` with `req_lst[sel]=0`: go to LOCK; `gnt <= sel`.
  - No request: hold.
- LOCK:
  - Only `gnt` is eligible; other requesters see `req_rdy=0` regardless of `req_val`.
  - `acc` with `req_lst[gnt]=1`: go to IDLE; `ptr <= gnt+1 mod NR`.
  - Otherwise stay in LOCK. Bubbles (`req_val[gnt]=0`) do not release the lock.
- Output register, when `ld`:
  - `out_val <= acc`.
  - If `acc`: `out_dat <= mux out`, `out_lst <= req_lst[sel]`, `out_src <= sel`.
  - When not `ld`, all output registers hold.

## Timing
- Reset (synchronous, wins over everything):
  - `out_val=0`, `out_lst=0`, `out_dat=0`, `out_src=0`.
  - `ptr=0`, `gnt=0`, `st=IDLE`.
  - `req_rdy` all 0 during any cycle with `rst=1`.
- Latency: a beat accepted at edge N appears on the outputs with `out_val=1` after edge N.
- Throughput: one beat per cycle while `out_rdy=1` and the selected requester is valid. Back-to-back packets from different requesters need no idle cycle.
- Backpressure: while `out_val=1 && out_rdy=0`, `out_*` are stable and `req_rdy` is all 0.
- Simultaneous drain and load: when `out_rdy=1` with `out_val=1`, the new beat loads in the same cycle.
- Reset mid-packet: the lock is abandoned. The partial packet is dropped downstream only by the consumer; the arbiter itself does not flush it.

## Test plan
1. **Reset:** `rst=1` for 3 cycles with `req_val=4'b1111`.
   - During reset: `req_rdy=0`, `out_val=0`.
   - Cycle after release: `req_rdy=4'b0001`; next cycle `out_src=0`.
2. **Fairness, single-beat:** NR=4, all `req_val=1`, `req_lst=1`, `out_rdy=1`.
   - `out_src` = 0,1,2,3,0,1 on consecutive cycles; `out_val` stays 1.
3. **Packet lock:** `ptr=1`; req1 sends a 3-beat packet (data 0xA,0xB,0xC, last on 0xC); req0 and req2 continuously valid.
   - Output: `out_src`=1,1,1 then 2 then 0.
   - `out_lst`=0,0,1.
   - A bubble on req1 between beats does not grant req2.
4. **Backpressure:** `out_rdy=0` for 5 cycles while `out_val=1`, `out_dat=0x5`.
   - Outputs frozen; `req_rdy=0`.
   - On release, the next beat appears one cycle later.
5. **Non-power-of-two wrap:** NR=3, all valid, single-beat.
   - `out_src` = 0,1,2,0; `ptr` never equals 3.
6. **Reset mid-packet:** `rst` pulsed in LOCK with `gnt=2`.
   - Next cycle: `st=IDLE`, `ptr=0`, `out_val=0`.
   - The following grant goes to the lowest valid requester.

Source files
------------

// File: rtl/pkt_rr_mux_arb_if.sv
// Requester/consumer bundle for the round-robin packet arbiter.
interface pkt_rr_mux_arb_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned NR = 4
);
  localparam int unsigned SW = $clog2(NR);

  logic [NR-1:0]    req_val;
  logic [NR-1:0]    req_lst;
  logic [DW*NR-1:0] req_dat;
  logic [NR-1:0]    req_rdy;
  logic             out_val;
  logic             out_lst;
  logic [DW-1:0]    out_dat;
  logic [SW-1:0]    out_src;
  logic             out_rdy;

  // Arbiter side: consumes requests, produces the output stream.
  modport slave (
    input  req_val, req_lst, req_dat, out_rdy,
    output req_rdy, out_val, out_lst, out_dat, out_src
  );

  // Environment side: producers and the consumer.
  modport master (
    output req_val, req_lst, req_dat, out_rdy,
    input  req_rdy, out_val, out_lst, out_dat, out_src
  );
endinterface

// File: rtl/pkt_rr_mux_arb.sv
// Data select for the arbiter: picks beat `sel` out of MW packed beats.
module mux #(
  parameter int unsigned DW = 4,
  parameter int unsigned MW = 4
) (
  input  logic [DW*MW-1:0]       inp,
  input  logic [$clog2(MW)-1:0]  sel,
  output logic [DW-1:0]          out
);
  localparam int unsigned SW = $clog2(MW);

  // One-of-MW selection; out-of-range selects yield zero.
  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (sel == SW'(i)) out = inp[i*DW +: DW];
    end
  end
endmodule

// Round-robin packet arbiter: locks onto one requester until its last beat,
// then forwards beats through a registered output stage with backpressure.
module pkt_rr_mux_arb #(
  parameter int unsigned DW = 4,
  parameter int unsigned NR = 4
) (
  input  logic              clk,
  input  logic              rst,
  pkt_rr_mux_arb_if.slave   bus
);
  localparam int unsigned SW = $clog2(NR);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_LOCK = 1'b1} st_t;

  st_t           r_st;
  st_t           w_st_nxt;
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] r_gnt;
  logic [SW-1:0] w_win;
  logic [SW-1:0] w_sel;
  logic [SW-1:0] w_sel_inc;
  logic          w_any;
  logic          w_ld;
  logic          w_acc;
  logic          w_lst;
  logic [NR-1:0] w_rdy;
  logic [DW-1:0] w_mux;
  int unsigned   w_idx;

  logic          r_out_val;
  logic          r_out_lst;
  logic [DW-1:0] r_out_dat;
  logic [SW-1:0] r_out_src;

  assign w_ld = !r_out_val || bus.out_rdy;

  // Rotating priority search: first valid requester at or after r_ptr.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= NR) w_idx = w_idx - NR;
      if (!w_any && bus.req_val[SW'(w_idx)]) begin
        w_any = 1'b1;
        w_win = SW'(w_idx);
      end
    end
  end

  // Shared datapath select.
  mux #(.DW(DW), .MW(NR)) u_mux (
    .inp (bus.req_dat),
    .sel (w_sel),
    .out (w_mux)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_st <= S_IDLE;
    else     r_st <= w_st_nxt;
  end

  // FSM next state: a non-last beat locks, the locked requester's last beat unlocks.
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      S_IDLE:  if (w_acc && !w_lst) w_st_nxt = S_LOCK;
      S_LOCK:  if (w_acc &&  w_lst) w_st_nxt = S_IDLE;
      default: w_st_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: current select, accept and the one-hot ready.
  always_comb begin
    w_sel     = (r_st == S_LOCK) ? r_gnt : w_win;
    w_acc     = w_ld && bus.req_val[w_sel] && ((r_st == S_LOCK) || w_any);
    w_lst     = bus.req_lst[w_sel];
    w_sel_inc = (w_sel == SW'(NR - 1)) ? '0 : w_sel + SW'(1);
    w_rdy     = '0;
    if (w_acc && !rst) w_rdy[w_sel] = 1'b1;
  end

  assign bus.req_rdy = w_rdy;

  // Priority pointer advances past a finished packet; grant captured on lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_gnt <= '0;
    end else if (w_acc) begin
      if (w_lst) r_ptr <= w_sel_inc;
      else       r_gnt <= w_sel;
    end
  end

  // Output stage: loads when empty or draining, holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_val <= 1'b0;
      r_out_lst <= 1'b0;
      r_out_dat <= '0;
      r_out_src <= '0;
    end else if (w_ld) begin
      r_out_val <= w_acc;
      if (w_acc) begin
        r_out_dat <= w_mux;
        r_out_lst <= w_lst;
        r_out_src <= w_sel;
      end
    end
  end

  assign bus.out_val = r_out_val;
  assign bus.out_lst = r_out_lst;
  assign bus.out_dat = r_out_dat;
  assign bus.out_src = r_out_src;
endmodule

// File: tb/tb_pkt_rr_mux_arb.sv
// Bench for pkt_rr_mux_arb: NR=4 and NR=3 instances share stimulus and are
// checked every cycle against a behavioural arbitration model.
module tb_pkt_rr_mux_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]  vv = 4'b1111;
  logic [3:0]  ll = 4'b1111;
  logic [15:0] dd = 16'h0;
  logic        ordy = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_rr_mux_arb_if #(.DW(4), .NR(4)) b4 ();
  pkt_rr_mux_arb_if #(.DW(4), .NR(3)) b3 ();

  assign b4.req_val = vv;
  assign b4.req_lst = ll;
  assign b4.req_dat = dd;
  assign b4.out_rdy = ordy;
  assign b3.req_val = vv[2:0];
  assign b3.req_lst = ll[2:0];
  assign b3.req_dat = dd[11:0];
  assign b3.out_rdy = ordy;

  pkt_rr_mux_arb #(.DW(4), .NR(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  pkt_rr_mux_arb #(.DW(4), .NR(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  typedef struct packed {
    int ptr;
    bit lock;
    int gnt;
    bit ov;
    bit ol;
    int od;
    int os;
  } ms_t;

  ms_t m4 = '0;
  ms_t m3 = '0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the arbiter described by its rules: returns next state and ready.
  function automatic void mstep(input ms_t s, input int nr, input bit [3:0] v,
                                input bit [3:0] l, input bit [15:0] d,
                                input bit o, input bit r,
                                output ms_t n, output bit [3:0] rdy);
    bit ld, have, acc;
    int sel;
    n = s;
    rdy = '0;
    if (r) begin
      n = '0;
      return;
    end
    ld = !s.ov || o;
    have = 1'b0;
    sel = 0;
    if (s.lock) begin
      sel = s.gnt;
      have = ((v >> sel) & 4'd1) != 0;
    end else begin
      for (int k = 0; k < nr; k++) begin
        int i;
        i = (s.ptr + k) % nr;
        if (!have && (((v >> i) & 4'd1) != 0)) begin
          have = 1'b1;
          sel = i;
        end
      end
    end
    acc = ld && have;
    if (acc) begin
      rdy = 4'(1 << sel);
      if (((l >> sel) & 4'd1) != 0) begin
        n.lock = 1'b0;
        n.ptr = (sel + 1) % nr;
      end else begin
        n.lock = 1'b1;
        n.gnt = sel;
      end
    end
    if (ld) begin
      n.ov = acc;
      if (acc) begin
        n.od = int'((d >> (4 * sel)) & 16'hF);
        n.ol = ((l >> sel) & 4'd1) != 0;
        n.os = sel;
      end
    end
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    ms_t n4, n3;
    bit [3:0] e4, e3;
    chk("val4", int'(b4.out_val), int'(m4.ov));
    chk("lst4", int'(b4.out_lst), int'(m4.ol));
    chk("dat4", int'(b4.out_dat), m4.od);
    chk("src4", int'(b4.out_src), m4.os);
    chk("val3", int'(b3.out_val), int'(m3.ov));
    chk("lst3", int'(b3.out_lst), int'(m3.ol));
    chk("dat3", int'(b3.out_dat), m3.od);
    chk("src3", int'(b3.out_src), m3.os);
    mstep(m4, 4, vv, ll, dd, ordy, rst, n4, e4);
    mstep(m3, 3, vv & 4'b0111, ll & 4'b0111, dd & 16'h0FFF, ordy, rst, n3, e3);
    chk("rdy4", int'(b4.req_rdy), int'(e4));
    chk("rdy3", int'(b3.req_rdy), int'(e3));
    m4 = n4;
    m3 = n3;
  end

  task automatic step_in(input bit [3:0] v, input bit [3:0] l, input bit [15:0] d,
                         input bit o, input bit r);
    @(posedge clk);
    #1;
    rst = r; vv = v; ll = l; dd = d; ordy = o;
    @(negedge clk);
    #1;
  endtask

  task automatic lit_rdy(input string nm, input int e4, input int e3);
    chk({nm, "_rdy4"}, int'(b4.req_rdy), e4);
    chk({nm, "_rdy3"}, int'(b3.req_rdy), e3);
  endtask

  task automatic lit_out4(input string nm, input int v, input int s, input int d, input int l);
    chk({nm, "_oval4"}, int'(b4.out_val), v);
    if (v != 0) begin
      chk({nm, "_osrc4"}, int'(b4.out_src), s);
      chk({nm, "_odat4"}, int'(b4.out_dat), d);
      chk({nm, "_olst4"}, int'(b4.out_lst), l);
    end
  endtask

  initial begin
    // Reset held with all requesters valid.
    for (int c = 0; c < 3; c++) begin
      step_in(4'b1111, 4'b1111, 16'h4321, 1'b1, 1'b1);
      lit_rdy("rst", 0, 0);
      chk("rst_oval4", int'(b4.out_val), 0);
    end

    // Single-beat fairness straight out of reset.
    for (int k = 0; k < 7; k++) begin
      step_in(4'b1111, 4'b1111, 16'h4321, 1'b1, 1'b0);
      lit_rdy("fair", 1 << (k % 4), 1 << (k % 3));
      if (k > 0) begin
        chk("fair_src4", int'(b4.out_src), (k - 1) % 4);
        chk("fair_src3", int'(b3.out_src), (k - 1) % 3);
        chk("fair_oval4", int'(b4.out_val), 1);
      end
    end

    // Move priority to requester 1 by serving requester 0.
    step_in(4'b0001, 4'b1111, 16'h4321, 1'b1, 1'b0);
    lit_rdy("pre", 1, 1);

    // Requester 1 three-beat packet with a bubble; 0 and 2 stay valid.
    step_in(4'b0111, 4'b0101, 16'h03A1, 1'b1, 1'b0);
    lit_rdy("pk1", 2, 2);
    step_in(4'b0111, 4'b0101, 16'h03B1, 1'b1, 1'b0);
    lit_rdy("pk2", 2, 2);
    lit_out4("pk2", 1, 1, 10, 0);
    step_in(4'b0101, 4'b0101, 16'h0301, 1'b1, 1'b0);
    lit_rdy("bub", 0, 0);
    lit_out4("bub", 1, 1, 11, 0);
    step_in(4'b0111, 4'b0111, 16'h03C1, 1'b1, 1'b0);
    lit_rdy("pk3", 2, 2);
    lit_out4("pk3", 0, 0, 0, 0);
    step_in(4'b0101, 4'b0101, 16'h0301, 1'b1, 1'b0);
    lit_rdy("pk4", 4, 4);
    lit_out4("pk4", 1, 1, 12, 1);
    step_in(4'b0101, 4'b0101, 16'h0301, 1'b1, 1'b0);
    lit_rdy("pk5", 1, 1);
    lit_out4("pk5", 1, 2, 3, 1);
    step_in(4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b0);
    lit_rdy("pk6", 0, 0);
    lit_out4("pk6", 1, 0, 1, 1);

    // Backpressure: out_dat=5 held for five stalled cycles.
    step_in(4'b0001, 4'b1111, 16'h0065, 1'b1, 1'b0);
    lit_rdy("bp0", 1, 1);
    for (int c = 0; c < 5; c++) begin
      step_in(4'b1111, 4'b1111, 16'h0065, 1'b0, 1'b0);
      lit_rdy("bp", 0, 0);
      lit_out4("bp", 1, 0, 5, 1);
    end
    step_in(4'b1111, 4'b1111, 16'h0065, 1'b1, 1'b0);
    lit_rdy("bprel", 2, 2);
    lit_out4("bprel", 1, 0, 5, 1);

    // Lock requester 2, then reset in the middle of its packet.
    step_in(4'b0100, 4'b0000, 16'h0765, 1'b1, 1'b0);
    lit_rdy("lk0", 4, 4);
    lit_out4("lk0", 1, 1, 6, 1);
    step_in(4'b0100, 4'b0000, 16'h0765, 1'b1, 1'b0);
    lit_rdy("lk1", 4, 4);
    step_in(4'b0110, 4'b0000, 16'h0765, 1'b1, 1'b1);
    lit_rdy("lkrst", 0, 0);
    step_in(4'b0110, 4'b0110, 16'h0765, 1'b1, 1'b0);
    lit_rdy("postrst", 2, 2);
    lit_out4("postrst", 0, 0, 0, 0);
    step_in(4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b0);
    lit_out4("postrst1", 1, 1, 6, 1);

    // Random traffic with occasional reset and stalls.
    for (int c = 0; c < 3000; c++) begin
      step_in(4'($urandom), 4'($urandom), 16'($urandom),
              ($urandom % 4) != 0, ($urandom % 100) == 0);
    end

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
